// File: rtl/writeback_sequencer_pkg.sv
// Shared codes for the writeback path: request kinds, destination/source mux
// selects and the sequencer state encoding.
package writeback_sequencer_pkg;

   localparam logic [2:0] KIND_ALU_RD = 3'd0;
   localparam logic [2:0] KIND_ALU_RT = 3'd1;
   localparam logic [2:0] KIND_LOAD   = 3'd2;
   localparam logic [2:0] KIND_JAL    = 3'd3;
   localparam logic [2:0] KIND_PUSH   = 3'd4;
   localparam logic [2:0] KIND_POP    = 3'd5;

   localparam logic [2:0] DST_RS  = 3'd0;
   localparam logic [2:0] DST_RT  = 3'd1;
   localparam logic [2:0] DST_RD  = 3'd2;
   localparam logic [2:0] DST_R29 = 3'd3;
   localparam logic [2:0] DST_R31 = 3'd4;

   localparam logic [2:0] SRC_ALU   = 3'd0;
   localparam logic [2:0] SRC_MDR   = 3'd1;
   localparam logic [2:0] SRC_PC    = 3'd2;
   localparam logic [2:0] SRC_SP_M4 = 3'd3;
   localparam logic [2:0] SRC_SP_P4 = 3'd4;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WB     = 3'd1;
   localparam logic [2:0] ST_SP_ADJ = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB_MEM = 3'd4;

   function automatic logic kind_is_legal(input logic [2:0] kind);
      return kind <= KIND_POP;
   endfunction

endpackage

// File: rtl/writeback_sequencer_mem_wait_timer.sv
// Counts MEM cycles spent waiting on the memory; expired_o flags the last
// allowed cycle so the sequencer can abort in that same cycle.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/writeback_sequencer.sv
// Multicycle writeback controller: sequences register-file writes and the
// memory handshake for loads and stack push/pop, one request at a time.
module writeback_sequencer
   import writeback_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic [2:0] req_kind,
   output logic       req_ready,
   input  logic       mem_ready,
   output logic [2:0] reg_dst,
   output logic [2:0] wb_src,
   output logic       reg_write,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sp,
   output logic       busy,
   output logic       done,
   output logic       err
);

   logic [2:0] state_q, state_d;
   logic [2:0] kind_q, kind_d;
   logic       expired;
   logic       in_mem;

   assign in_mem = (state_q == ST_MEM);

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .clear_i  (!in_mem),
      .en_i     (in_mem && !mem_ready),
      .expired_o(expired)
   );

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               kind_d = req_kind;
               case (req_kind)
                  KIND_LOAD, KIND_POP: state_d = ST_MEM;
                  KIND_PUSH:           state_d = ST_SP_ADJ;
                  default:             state_d = ST_WB;
               endcase
            end
         end
         ST_WB:     state_d = ST_IDLE;
         ST_SP_ADJ: state_d = (kind_q == KIND_PUSH) ? ST_MEM : ST_IDLE;
         ST_MEM: begin
            // A ready in the limit cycle wins over the timeout.
            if (mem_ready) begin
               case (kind_q)
                  KIND_POP:  state_d = ST_WB_MEM;
                  KIND_LOAD: state_d = ST_WB;
                  default:   state_d = ST_IDLE;
               endcase
            end else if (expired) begin
               state_d = ST_IDLE;
            end
         end
         ST_WB_MEM: state_d = ST_SP_ADJ;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         kind_q  <= KIND_ALU_RD;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
      end
   end

   always_comb begin
      req_ready   = (state_q == ST_IDLE);
      busy        = (state_q != ST_IDLE);
      reg_dst     = DST_RS;
      wb_src      = SRC_ALU;
      reg_write   = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr_sp = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      case (state_q)
         ST_WB: begin
            if (kind_is_legal(kind_q)) begin
               reg_write = 1'b1;
               done      = 1'b1;
               case (kind_q)
                  KIND_ALU_RD: begin reg_dst = DST_RD;  wb_src = SRC_ALU; end
                  KIND_JAL:    begin reg_dst = DST_R31; wb_src = SRC_PC;  end
                  KIND_LOAD:   begin reg_dst = DST_RT;  wb_src = SRC_MDR; end
                  default:     begin reg_dst = DST_RT;  wb_src = SRC_ALU; end
               endcase
            end else begin
               err = 1'b1;
            end
         end
         ST_SP_ADJ: begin
            reg_write = 1'b1;
            reg_dst   = DST_R29;
            wb_src    = (kind_q == KIND_PUSH) ? SRC_SP_M4 : SRC_SP_P4;
            done      = (kind_q != KIND_PUSH);
         end
         ST_MEM: begin
            mem_req     = 1'b1;
            mem_we      = (kind_q == KIND_PUSH);
            mem_addr_sp = (kind_q != KIND_LOAD);
            if (mem_ready) begin
               done = (kind_q == KIND_PUSH);
            end else if (expired) begin
               err = 1'b1;
            end
         end
         ST_WB_MEM: begin
            reg_write = 1'b1;
            reg_dst   = DST_RT;
            wb_src    = SRC_MDR;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Bench for writeback_sequencer: directed scenarios followed by random
// request/ready traffic, every cycle compared against a per-request trace model.
module tb_writeback_sequencer;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req_valid;
   logic [2:0] req_kind;
   logic       req_ready;
   logic       mem_ready;
   logic [2:0] reg_dst;
   logic [2:0] wb_src;
   logic       reg_write;
   logic       mem_req;
   logic       mem_we;
   logic       mem_addr_sp;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   logic [13:0] exp_q[$];
   bit          mr_q[$];

   writeback_sequencer #(
      .MEM_TIMEOUT(T)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_kind   (req_kind),
      .req_ready  (req_ready),
      .mem_ready  (mem_ready),
      .reg_dst    (reg_dst),
      .wb_src     (wb_src),
      .reg_write  (reg_write),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr_sp(mem_addr_sp),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   logic [13:0] obs;
   assign obs = {busy, req_ready, reg_write, reg_dst, wb_src,
                 mem_req, mem_we, mem_addr_sp, done, err};

   // Output vector while idle: only req_ready is high.
   localparam logic [13:0] IDLE_V = 14'b01_0_000_000_00000;

   function automatic logic [13:0] vec(input bit rw, input int dst, input int src,
                                       input bit mrq, input bit mwe, input bit msp,
                                       input bit dn, input bit er);
      return {1'b1, 1'b0, rw, 3'(dst), 3'(src), mrq, mwe, msp, dn, er};
   endfunction

   task automatic check(input logic [13:0] expv, input string tag);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic add(input logic [13:0] v, input bit in_mem, input bit mr);
      exp_q.push_back(v);
      mr_q.push_back(in_mem ? mr : 1'($urandom));
   endtask

   // Memory wait: ready arrives in MEM cycle rdy_at (1-based) if within T cycles.
   task automatic add_mem(input bit we, input bit sp, input bit done_ok,
                          input int rdy_at, output bit ok);
      ok = 1'b0;
      for (int j = 1; j <= T; j++) begin
         if (rdy_at == j) begin
            add(vec(0, 0, 0, 1, we, sp, done_ok, 0), 1, 1);
            ok = 1'b1;
            break;
         end else if (j == T) begin
            add(vec(0, 0, 0, 1, we, sp, 0, 1), 1, 0);
         end else begin
            add(vec(0, 0, 0, 1, we, sp, 0, 0), 1, 0);
         end
      end
   endtask

   task automatic build(input int kind, input int rdy_at);
      bit ok;
      exp_q.delete();
      mr_q.delete();
      case (kind)
         0: add(vec(1, 2, 0, 0, 0, 0, 1, 0), 0, 0);
         1: add(vec(1, 1, 0, 0, 0, 0, 1, 0), 0, 0);
         3: add(vec(1, 4, 2, 0, 0, 0, 1, 0), 0, 0);
         2: begin
            add_mem(0, 0, 0, rdy_at, ok);
            if (ok) add(vec(1, 1, 1, 0, 0, 0, 1, 0), 0, 0);
         end
         4: begin
            add(vec(1, 3, 3, 0, 0, 0, 0, 0), 0, 0);
            add_mem(1, 1, 1, rdy_at, ok);
         end
         5: begin
            add_mem(0, 1, 0, rdy_at, ok);
            if (ok) begin
               add(vec(1, 1, 1, 0, 0, 0, 0, 0), 0, 0);
               add(vec(1, 3, 4, 0, 0, 0, 1, 0), 0, 0);
            end
         end
         default: add(vec(0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
      endcase
   endtask

   task automatic run_txn(input int kind, input int rdy_at, input string tag);
      @(negedge clk);
      req_valid = 1'b1;
      req_kind  = 3'(kind);
      mem_ready = 1'($urandom);
      #1 check(IDLE_V, {tag, "_accept"});
      build(kind, rdy_at);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         req_valid = 1'($urandom);
         req_kind  = 3'($urandom);
         mem_ready = mr_q[i];
         #1 check(exp_q[i], $sformatf("%s_c%0d", tag, i + 1));
      end
      req_valid = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_kind  = 3'd0;
      mem_ready = 1'b0;
      #1 check(IDLE_V, "reset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1 check(IDLE_V, "post_reset");

      run_txn(0, 0, "alu_rd");
      run_txn(1, 0, "alu_rt");
      run_txn(3, 0, "jal");
      run_txn(2, 3, "load_rdy3");
      run_txn(2, T, "load_rdy_at_limit");
      run_txn(4, 1, "push");
      run_txn(5, 1, "pop");
      run_txn(5, 0, "pop_timeout");
      run_txn(4, 0, "push_timeout");
      run_txn(6, 0, "illegal6");
      run_txn(7, 0, "illegal7");

      // Async reset while a PUSH waits in MEM.
      @(negedge clk);
      req_valid = 1'b1;
      req_kind  = 3'd4;
      #1 check(IDLE_V, "rst_push_accept");
      @(negedge clk);
      req_valid = 1'b0;
      mem_ready = 1'b0;
      #1 check(vec(1, 3, 3, 0, 0, 0, 0, 0), "rst_push_spadj");
      @(negedge clk);
      #1 check(vec(0, 0, 0, 1, 1, 1, 0, 0), "rst_push_mem");
      #1 reset_n = 1'b0;
      #1 check(IDLE_V, "rst_async");
      @(negedge clk);
      reset_n = 1'b1;
      #1 check(IDLE_V, "rst_release");
      run_txn(0, 0, "after_reset");

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ready = 1'($urandom);
            #1 check(IDLE_V, "rand_idle");
         end
         run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, T + 1)),
                 $sformatf("rand%0d", n));
      end

      @(negedge clk);
      #1 check(IDLE_V, "final_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
